disp_sevenseg_scan: RTL

- Time-multiplexed driver for the 4-digit common-anode 7-segment display.
- Consumes the 4-bit digit values produced by the score counter (hex2/hex3) and the other digit sources (hex0/hex1).
- Latches a coherent frame snapshot, scans one digit per slot with an anti-ghosting blank gap, and decodes each digit to active-low segments.
- Sits between the score/control logic and the board display pins.

---
 rtl/disp_sevenseg_scan_if.sv | 23 ++
 rtl/disp_sevenseg_scan.sv | 118 +++++++++++
 2 files changed

// File: rtl/disp_sevenseg_scan_if.sv
// Digit sources to 7-segment scan driver: digit values, enable and dp
// requests in; active-low anode, segment and decimal point drives out.
interface disp_sevenseg_scan_if;
  logic       en;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic [3:0] hex2;
  logic [3:0] hex3;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output en, hex0, hex1, hex2, hex3, dp_in,
    input  an, seg, dp
  );

  modport slave (
    input  en, hex0, hex1, hex2, hex3, dp_in,
    output an, seg, dp
  );
endinterface

// File: rtl/disp_sevenseg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame snapshot
// and anti-ghosting blank gap. Optional macro: DISP_LEADING_ZERO_BLANK_EN.
module disp_sevenseg_scan #(
  parameter int DIGIT_PERIOD_CYCLES = 65000,
  parameter int BLANK_CYCLES        = 650
) (
  input  logic                 clk,
  input  logic                 rst,
  disp_sevenseg_scan_if.slave  bus
);

  localparam int CNT_W = (DIGIT_PERIOD_CYCLES > 1) ? $clog2(DIGIT_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam bit               HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  state_t           state_q, state_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             wrap;
  logic [3:0]       lz_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    lz_mask = 4'b0000;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    lz_mask[3] = (snap_q[3] == 4'h0);
    lz_mask[2] = lz_mask[3] && (snap_q[2] == 4'h0);
    lz_mask[1] = lz_mask[2] && (snap_q[1] == 4'h0);
`endif
  end

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    // Capture on the last cycle of digit 3 so the whole next frame is coherent.
    if (wrap && (idx_q == 2'd3)) begin
      snap_d    = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
      snap_dp_d = bus.dp_in;
    end

    // state_d tracks cnt_d so state_q always describes the registered cnt_q.
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (!HAS_BLANK || (cnt_d == CNT_BLANK)) state_d = ST_SHOW;
      ST_SHOW:  if (HAS_BLANK && wrap)                   state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (bus.en && (state_q == ST_SHOW)) begin
      an_d[idx_q] = 1'b0;
      seg_d       = lz_mask[idx_q] ? 7'b1111111 : hex_to_seg(snap_q[idx_q]);
      dp_d        = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      state_q   <= ST_BLANK;
      snap_q    <= '0;
      snap_dp_q <= 4'b0000;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule
